seq_divider16: RTL and testbench



---
 rtl/seq_divider16.sv | 143 ++++++++++++++
 tb/tb_seq_divider16.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider16.sv
// Multi-cycle restoring shift-subtract divider with a start/ready/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module seq_divider16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_divByZero;

    logic [WIDTH:0]     w_remShift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_newRem;
    logic [WIDTH-1:0]   w_newQuo;
    logic [WIDTH-1:0]   w_dvdMag;
    logic [WIDTH-1:0]   w_dvsMag;
    logic [WIDTH-1:0]   w_resQuo;
    logic [WIDTH-1:0]   w_resRem;

    // Trial subtract as an add of the inverted divisor with carry-in 1; the top bit is the carry.
    // Bit WIDTH is always the inverse of the carry here, so folding it in costs nothing.
    assign w_remShift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = {1'b0, w_remShift} + {1'b0, ~{1'b0, r_divisor}} + (WIDTH+2)'(1);
    assign w_ge       = w_diff[WIDTH+1] & ~w_diff[WIDTH];
    assign w_newRem   = w_ge ? w_diff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
    assign w_newQuo   = {r_quo[WIDTH-2:0], w_ge};

`ifdef SEQ_DIV_SIGNED_EN
    logic r_negQuo;
    logic r_negRem;

    assign w_dvdMag = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_dvsMag = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign w_resQuo = r_negQuo ? -w_newQuo : w_newQuo;
    assign w_resRem = r_negRem ? -w_newRem : w_newRem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_negQuo <= 1'b0;
            r_negRem <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_negQuo <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_negRem <= dividend[WIDTH-1];
        end
    end
`else
    assign w_dvdMag = dividend;
    assign w_dvsMag = divisor;
    assign w_resQuo = w_newQuo;
    assign w_resRem = w_newRem;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divByZero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ready   <= 1'b0;
                        r_quo     <= w_dvdMag;
                        r_divisor <= w_dvsMag;
                        r_rem     <= '0;
                        r_count   <= '0;
                        if (divisor != '0) begin
                            r_busy  <= 1'b1;
                            r_state <= RUN;
                        end else begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_divByZero <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end
                RUN: begin
                    r_rem   <= w_newRem;
                    r_quo   <= w_newQuo;
                    r_count <= r_count + 1'b1;
                    if (r_count == CNT_W'(WIDTH-1)) begin
                        r_quotient  <= w_resQuo;
                        r_remainder <= w_resRem;
                        r_divByZero <= 1'b0;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready       = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_seq_divider16.sv
// Directed self-checking bench for seq_divider16 with hand-computed quotients and remainders.
// Signed vectors are included when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_divider16;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checkCount = 0;
    int errorCount = 0;
    int doneCount  = 0;

    seq_divider16 #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Present one request for a single accept edge, then scramble the operands.
    task automatic startOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
    endtask

    task automatic waitDone(output int lat, output int busyCycles);
        lat        = -1;
        busyCycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (busy === 1'b1) busyCycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] expQ, input logic [WIDTH-1:0] expR,
                                 input logic expZ, input int expLat);
        int lat;
        int busyCycles;
        int d0;
        startOp(a, b);
        checkOutput({tag, ".readyDrop"}, 32'(ready), 32'd0);
        d0 = doneCount;
        waitDone(lat, busyCycles);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ".busyCycles"}, 32'(busyCycles), 32'(expLat));
        checkOutput({tag, ".quotient"}, 32'(quotient), 32'(expQ));
        checkOutput({tag, ".remainder"}, 32'(remainder), 32'(expR));
        checkOutput({tag, ".divByZero"}, 32'(div_by_zero), 32'(expZ));
        @(posedge clk);
        #1;
        checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
        checkOutput({tag, ".readyBack"}, 32'(ready), 32'd1);
        checkOutput({tag, ".doneCount"}, 32'(doneCount - d0), 32'd1);
    endtask

    initial begin
        int lat;
        int busyCycles;
        int d0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.ready", 32'(ready), 32'd1);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.quotient", 32'(quotient), 32'd0);
        checkOutput("reset.remainder", 32'(remainder), 32'd0);
        checkOutput("reset.divByZero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("d100by7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
        applyStimulus("dFFFFby1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16);
        applyStimulus("dFFFFbyFFFF", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 16);
        applyStimulus("d3by10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 16);
        applyStimulus("d0by5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 16);
        applyStimulus("d5by0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0);
        applyStimulus("d12by4", 16'd12, 16'd4, 16'd3, 16'd0, 1'b0, 16);

        // A start pulse during RUN must be dropped without disturbing the running divide.
        startOp(16'd1000, 16'd3);
        d0 = doneCount;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(negedge clk);
        start    = 1'b0;
        waitDone(lat, busyCycles);
        checkOutput("ignoreStart.latency", 32'(lat), 32'd12);
        checkOutput("ignoreStart.quotient", 32'(quotient), 32'd333);
        checkOutput("ignoreStart.remainder", 32'(remainder), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("ignoreStart.doneCount", 32'(doneCount - d0), 32'd1);
        checkOutput("ignoreStart.ready", 32'(ready), 32'd1);
        checkOutput("ignoreStart.quotientHeld", 32'(quotient), 32'd333);

        // Reset mid-RUN aborts with no done and returns every output to its reset value.
        startOp(16'd1000, 16'd3);
        d0 = doneCount;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort.ready", 32'(ready), 32'd1);
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkOutput("abort.done", 32'(done), 32'd0);
        checkOutput("abort.quotient", 32'(quotient), 32'd0);
        checkOutput("abort.remainder", 32'(remainder), 32'd0);
        checkOutput("abort.divByZero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort.noDone", 32'(doneCount - d0), 32'd0);
        applyStimulus("d9by2", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 16);

`ifdef SEQ_DIV_SIGNED_EN
        applyStimulus("sNeg7by2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 16);
        applyStimulus("s7byNeg2", 16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, 16);
        applyStimulus("sMinByNeg1", 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 16);
`else
        applyStimulus("d40000by300", 16'd40000, 16'd300, 16'd133, 16'd100, 1'b0, 16);
        applyStimulus("d8000byFFFF", 16'h8000, 16'hFFFF, 16'd0, 16'h8000, 1'b0, 16);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
